// File: rtl/decode_queue_pkg.sv
// rtl/decode_queue_pkg.sv - opcodes, OpInfo record and immediate extraction shared by decode_queue
package decode_queue_pkg;

  localparam int INSN_ADDR_WIDTH = 32;

  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;

  localparam logic [6:0] FUNCT7_ADD    = 7'b0000000;
  localparam logic [6:0] FUNCT7_SUB    = 7'b0100000;
  localparam logic [6:0] FUNCT7_MULDIV = 7'b0000001;

  localparam logic [2:0] ADD_SUB = 3'b000;

  typedef enum logic [2:0] {
    IMM_I,
    IMM_S,
    IMM_B,
    IMM_U,
    IMM_J,
    IMM_NONE
  } ImmType;

  // aluAlt marks SUB and SRA/SRAI, which share funct3 with ADD and SRL/SRLI
  typedef struct packed {
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [4:0]  rd;
    logic [31:0] constant;
    logic [2:0]  aluCode;
    logic [2:0]  brCode;
    logic        regWrEnable;
    logic        isBranch;
    logic        isJump;
    logic        isLoad;
    logic        isStore;
    logic        isALUInConstant;
    logic        aluAlt;
    logic        isMulDiv;
    logic        isIllegal;
  } OpInfo;

  function automatic logic [31:0] imm_extract(input logic [31:0] insn, input ImmType kind);
    logic [31:0] imm;
    case (kind)
      IMM_I:   imm = {{20{insn[31]}}, insn[31:20]};
      IMM_S:   imm = {{20{insn[31]}}, insn[31:25], insn[11:7]};
      IMM_B:   imm = {{19{insn[31]}}, insn[31], insn[7], insn[30:25], insn[11:8], 1'b0};
      IMM_U:   imm = {insn[31:12], 12'b0};
      IMM_J:   imm = {{11{insn[31]}}, insn[31], insn[19:12], insn[20], insn[30:21], 1'b0};
      default: imm = '0;
    endcase
    return imm;
  endfunction

endpackage

// File: rtl/decode_queue_decoder.sv
// rtl/decode_queue_decoder.sv - combinational RV32I decoder (insn_decoder); RV32M via DECODE_QUEUE_RV32M_EN
module insn_decoder
  import decode_queue_pkg::*;
(
  input  logic [31:0] i_insn,
  output OpInfo       o_info
);

  logic [6:0] w_opcode;
  logic [6:0] w_funct7;
  logic [2:0] w_funct3;
  ImmType     w_imm_type;
  logic       w_legal;
  logic       w_is_shift;

  assign w_opcode = i_insn[6:0];
  assign w_funct3 = i_insn[14:12];
  assign w_funct7 = i_insn[31:25];

  always_comb begin
    o_info     = '0;
    w_imm_type = IMM_NONE;
    w_legal    = 1'b1;
    w_is_shift = 1'b0;

    o_info.rs1     = i_insn[19:15];
    o_info.rs2     = i_insn[24:20];
    o_info.rd      = i_insn[11:7];
    o_info.brCode  = w_funct3;
    o_info.aluCode = ADD_SUB;

    case (w_opcode)
      OPC_LOAD: begin
        w_imm_type             = IMM_I;
        o_info.regWrEnable     = 1'b1;
        o_info.isLoad          = 1'b1;
        o_info.isALUInConstant = 1'b1;
        w_legal = !((w_funct3 == 3'b011) || (w_funct3[2:1] == 2'b11));
      end
      OPC_STORE: begin
        w_imm_type             = IMM_S;
        o_info.isStore         = 1'b1;
        o_info.isALUInConstant = 1'b1;
        w_legal = !((w_funct3 == 3'b011) || (w_funct3[2:1] == 2'b11));
      end
      OPC_BRANCH: begin
        w_imm_type      = IMM_B;
        o_info.isBranch = 1'b1;
        w_legal         = (w_funct3[2:1] != 2'b01);
      end
      OPC_OP_IMM: begin
        w_imm_type             = IMM_I;
        o_info.regWrEnable     = 1'b1;
        o_info.isALUInConstant = 1'b1;
        o_info.aluCode         = w_funct3;
        if ((w_funct3 == 3'b001) || (w_funct3 == 3'b101)) begin
          w_is_shift    = 1'b1;
          w_legal       = !i_insn[25];
          o_info.aluAlt = (w_funct3 == 3'b101) && i_insn[30];
        end
      end
      OPC_OP: begin
        o_info.regWrEnable = 1'b1;
        o_info.aluCode     = w_funct3;
        if (w_funct7 == FUNCT7_SUB) begin
          o_info.aluAlt = 1'b1;
          w_legal       = (w_funct3 == 3'b000) || (w_funct3 == 3'b101);
        end
`ifdef DECODE_QUEUE_RV32M_EN
        else if (w_funct7 == FUNCT7_MULDIV) begin
          o_info.isMulDiv = 1'b1;
        end
`endif
        else if (w_funct7 != FUNCT7_ADD) begin
          w_legal = 1'b0;
        end
      end
      OPC_LUI, OPC_AUIPC: begin
        w_imm_type             = IMM_U;
        o_info.regWrEnable     = 1'b1;
        o_info.isALUInConstant = 1'b1;
      end
      OPC_JAL: begin
        w_imm_type         = IMM_J;
        o_info.regWrEnable = 1'b1;
        o_info.isJump      = 1'b1;
      end
      OPC_JALR: begin
        w_imm_type             = IMM_I;
        o_info.regWrEnable     = 1'b1;
        o_info.isJump          = 1'b1;
        o_info.isALUInConstant = 1'b1;
      end
      default: w_legal = 1'b0;
    endcase

    o_info.constant = w_is_shift ? {27'b0, i_insn[24:20]} : imm_extract(i_insn, w_imm_type);

    if (o_info.rd == 5'd0) o_info.regWrEnable = 1'b0;

    // illegal words stay in program order but must not cause side effects downstream
    if (!w_legal) begin
      o_info.regWrEnable     = 1'b0;
      o_info.isBranch        = 1'b0;
      o_info.isJump          = 1'b0;
      o_info.isLoad          = 1'b0;
      o_info.isStore         = 1'b0;
      o_info.isALUInConstant = 1'b0;
      o_info.isMulDiv        = 1'b0;
    end
    o_info.isIllegal = !w_legal;
  end

endmodule

// File: rtl/decode_queue.sv
// rtl/decode_queue.sv - registered RV32I decode plus DEPTH-entry in-order FIFO with flush
module decode_queue
  import decode_queue_pkg::*;
#(
  parameter int DEPTH    = 4,
  parameter int PC_WIDTH = INSN_ADDR_WIDTH
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     flush,
  input  logic                     inValid,
  output logic                     inReady,
  input  logic [31:0]              inInsn,
  input  logic [PC_WIDTH-1:0]      inPC,
  output logic                     outValid,
  input  logic                     outReady,
  output OpInfo                    outInfo,
  output logic [PC_WIDTH-1:0]      outPC,
  output logic                     outIllegal,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int AW = $clog2(DEPTH);
  typedef logic [AW:0] QueueCountPath;
  localparam QueueCountPath DEPTH_C = QueueCountPath'(DEPTH);
  localparam QueueCountPath ONE_C   = QueueCountPath'(1);

  OpInfo               r_info [DEPTH];
  logic [PC_WIDTH-1:0] r_pc   [DEPTH];
  QueueCountPath       r_wr_ptr;
  QueueCountPath       r_rd_ptr;

  QueueCountPath w_count;
  logic [AW-1:0] w_wr_idx;
  logic [AW-1:0] w_rd_idx;
  logic          w_push;
  logic          w_pop;
  OpInfo         w_dec_info;

  insn_decoder u_decoder (
    .i_insn (inInsn),
    .o_info (w_dec_info)
  );

  // pointer MSB separates full from empty, so the difference is the occupancy
  assign w_count  = r_wr_ptr - r_rd_ptr;
  assign w_wr_idx = r_wr_ptr[AW-1:0];
  assign w_rd_idx = r_rd_ptr[AW-1:0];

  assign inReady  = (w_count < DEPTH_C);
  assign outValid = (w_count != '0);
  assign count    = w_count;

  assign w_push = inValid && inReady && !flush;
  assign w_pop  = outValid && outReady;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
    end else if (flush) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + ONE_C;
      if (w_pop)  r_rd_ptr <= r_rd_ptr + ONE_C;
    end
  end

  always_ff @(posedge clk) begin
    if (w_push) begin
      r_info[w_wr_idx] <= w_dec_info;
      r_pc[w_wr_idx]   <= inPC;
    end
  end

  // storage is not reset, so outputs are gated to read zero while empty
  assign outInfo    = outValid ? r_info[w_rd_idx] : '0;
  assign outPC      = outValid ? r_pc[w_rd_idx] : '0;
  assign outIllegal = outInfo.isIllegal;

endmodule

// File: tb/tb_decode_queue.sv
// tb/tb_decode_queue.sv - self-checking bench for decode_queue against a queue-based reference model
module tb_decode_queue;
  import decode_queue_pkg::*;

  localparam int DEPTH = 4;

  typedef struct {
    OpInfo       info;
    logic [31:0] pc;
  } entry_t;

  logic        clk = 1'b0;
  logic        rst;
  logic        flush;
  logic        inValid;
  logic        inReady;
  logic [31:0] inInsn;
  logic [31:0] inPC;
  logic        outValid;
  logic        outReady;
  OpInfo       outInfo;
  logic [31:0] outPC;
  logic        outIllegal;
  logic [2:0]  count;

  int     checks = 0;
  int     errors = 0;
  entry_t mq[$];

  decode_queue #(.DEPTH(DEPTH), .PC_WIDTH(32)) dut (
    .clk        (clk),
    .rst        (rst),
    .flush      (flush),
    .inValid    (inValid),
    .inReady    (inReady),
    .inInsn     (inInsn),
    .inPC       (inPC),
    .outValid   (outValid),
    .outReady   (outReady),
    .outInfo    (outInfo),
    .outPC      (outPC),
    .outIllegal (outIllegal),
    .count      (count)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic OpInfo model_decode(input logic [31:0] w);
    OpInfo m;
    int    hi;
    int    imm;
    logic  ok;
    logic [2:0] f3;
    logic [6:0] f7;
    m   = '0;
    f3  = w[14:12];
    f7  = w[31:25];
    hi  = w[31] ? -1 : 0;
    imm = 0;
    ok  = 1'b1;
    m.rs1    = w[19:15];
    m.rs2    = w[24:20];
    m.rd     = w[11:7];
    m.brCode = f3;
    case (w[6:0])
      7'h03: begin
        imm = hi * 4096 + int'(w[31:20]);
        m.regWrEnable = 1; m.isLoad = 1; m.isALUInConstant = 1;
        ok = !(f3 == 3 || f3 == 6 || f3 == 7);
      end
      7'h23: begin
        imm = hi * 4096 + int'(w[31:25]) * 32 + int'(w[11:7]);
        m.isStore = 1; m.isALUInConstant = 1;
        ok = !(f3 == 3 || f3 == 6 || f3 == 7);
      end
      7'h63: begin
        imm = hi * 4096 + int'(w[7]) * 2048 + int'(w[30:25]) * 32 + int'(w[11:8]) * 2;
        m.isBranch = 1;
        ok = !(f3 == 2 || f3 == 3);
      end
      7'h13: begin
        imm = hi * 4096 + int'(w[31:20]);
        m.regWrEnable = 1; m.isALUInConstant = 1; m.aluCode = f3;
        if (f3 == 1 || f3 == 5) begin
          imm = int'(w[24:20]);
          ok = !w[25];
          m.aluAlt = (f3 == 5) && w[30];
        end
      end
      7'h33: begin
        m.regWrEnable = 1; m.aluCode = f3;
        if (f7 == 7'd32) begin
          m.aluAlt = 1;
          ok = (f3 == 0 || f3 == 5);
        end else if (f7 == 7'd1) begin
`ifdef DECODE_QUEUE_RV32M_EN
          m.isMulDiv = 1;
`else
          ok = 0;
`endif
        end else if (f7 != 7'd0) begin
          ok = 0;
        end
      end
      7'h37, 7'h17: begin
        imm = int'(w & 32'hFFFFF000);
        m.regWrEnable = 1; m.isALUInConstant = 1;
      end
      7'h6F: begin
        imm = hi * 1048576 + int'(w[19:12]) * 4096 + int'(w[20]) * 2048 + int'(w[30:21]) * 2;
        m.regWrEnable = 1; m.isJump = 1;
      end
      7'h67: begin
        imm = hi * 4096 + int'(w[31:20]);
        m.regWrEnable = 1; m.isJump = 1; m.isALUInConstant = 1;
      end
      default: ok = 0;
    endcase
    m.constant = imm;
    if (w[11:7] == 5'd0) m.regWrEnable = 0;
    if (!ok) begin
      m.regWrEnable = 0; m.isBranch = 0; m.isJump = 0; m.isLoad = 0;
      m.isStore = 0; m.isALUInConstant = 0; m.isMulDiv = 0;
    end
    m.isIllegal = !ok;
    return m;
  endfunction

  function automatic logic [31:0] rand_insn();
    logic [31:0] w;
    logic [6:0]  ops [9];
    int          k;
    ops = '{7'h03, 7'h23, 7'h63, 7'h13, 7'h33, 7'h37, 7'h17, 7'h6F, 7'h67};
    w = $urandom;
    k = $urandom_range(0, 11);
    if (k < 9) w[6:0] = ops[k];
    if (k == 9)  begin w[6:0] = 7'h33; w[31:25] = 7'd1; end
    if (k == 10) begin w[6:0] = 7'h33; w[31:25] = 7'd32; end
    return w;
  endfunction

  task automatic check_state(input string tag);
    chk({tag, "/count"}, 64'(count), 64'(mq.size()));
    chk({tag, "/outValid"}, 64'(outValid), 64'(mq.size() != 0));
    chk({tag, "/inReady"}, 64'(inReady), 64'(mq.size() < DEPTH));
    if (mq.size() != 0) begin
      chk({tag, "/outInfo"}, 64'(outInfo), 64'(mq[0].info));
      chk({tag, "/outPC"}, 64'(outPC), 64'(mq[0].pc));
      chk({tag, "/outIllegal"}, 64'(outIllegal), 64'(mq[0].info.isIllegal));
    end else begin
      chk({tag, "/outInfoEmpty"}, 64'(outInfo), 64'(0));
    end
  endtask

  task automatic cycle(input string tag, input logic v, input logic [31:0] insn,
                       input logic [31:0] pc, input logic rdy, input logic fl);
    int     sz;
    entry_t e;
    inValid  = v;
    inInsn   = insn;
    inPC     = pc;
    outReady = rdy;
    flush    = fl;
    sz = mq.size();
    if (fl) begin
      mq.delete();
    end else begin
      if (sz != 0 && rdy) void'(mq.pop_front());
      if (v && sz < DEPTH) begin
        e.info = model_decode(insn);
        e.pc   = pc;
        mq.push_back(e);
      end
    end
    @(posedge clk);
    #1;
    check_state(tag);
  endtask

  initial begin
    rst = 1'b0; flush = 1'b0; inValid = 1'b0; outReady = 1'b0; inInsn = '0; inPC = '0;
    #3;
    chk("reset/count", 64'(count), 64'(0));
    chk("reset/outValid", 64'(outValid), 64'(0));
    chk("reset/inReady", 64'(inReady), 64'(1));
    chk("reset/outInfo", 64'(outInfo), 64'(0));
    chk("reset/outPC", 64'(outPC), 64'(0));
    chk("reset/outIllegal", 64'(outIllegal), 64'(0));
    @(posedge clk); #1;
    rst = 1'b1;

    cycle("addi", 1, 32'hFFF00093, 32'h100, 0, 0);
    chk("addi/rd", 64'(outInfo.rd), 64'(1));
    chk("addi/constant", 64'(outInfo.constant), 64'(32'hFFFFFFFF));
    chk("addi/regWr", 64'(outInfo.regWrEnable), 64'(1));
    chk("addi/aluConst", 64'(outInfo.isALUInConstant), 64'(1));
    chk("addi/illegal", 64'(outIllegal), 64'(0));
    cycle("addi_pop", 0, 0, 0, 1, 0);

    cycle("beq", 1, 32'hFE000EE3, 32'h104, 0, 0);
    chk("beq/constant", 64'(outInfo.constant), 64'(32'hFFFFFFFC));
    chk("beq/isBranch", 64'(outInfo.isBranch), 64'(1));
    chk("beq/brCode", 64'(outInfo.brCode), 64'(0));
    chk("beq/pc", 64'(outPC), 64'(32'h104));
    cycle("lui", 1, 32'h123452B7, 32'h108, 1, 0);
    chk("lui/constant", 64'(outInfo.constant), 64'(32'h12345000));
    chk("lui/pc", 64'(outPC), 64'(32'h108));
    cycle("lui_pop", 0, 0, 0, 1, 0);

    for (int i = 0; i < 4; i++) cycle("fill", 1, rand_insn(), 32'h200 + 32'(i * 4), 0, 0);
    chk("full/count", 64'(count), 64'(4));
    chk("full/inReady", 64'(inReady), 64'(0));
    cycle("drain1", 1, rand_insn(), 32'h210, 1, 0);
    chk("drain1/count", 64'(count), 64'(3));
    cycle("refill", 1, rand_insn(), 32'h214, 1, 0);
    chk("refill/count", 64'(count), 64'(3));
    for (int i = 0; i < 3; i++) cycle("drain", 0, 0, 0, 1, 0);

    cycle("zero", 1, 32'h00000000, 32'h300, 0, 0);
    chk("zero/illegal", 64'(outIllegal), 64'(1));
    chk("zero/flags", 64'({outInfo.regWrEnable, outInfo.isBranch, outInfo.isJump, outInfo.isLoad,
                           outInfo.isStore, outInfo.isALUInConstant, outInfo.isMulDiv}), 64'(0));
    cycle("mul", 1, 32'h022081B3, 32'h304, 1, 0);
`ifdef DECODE_QUEUE_RV32M_EN
    chk("mul/isMulDiv", 64'(outInfo.isMulDiv), 64'(1));
    chk("mul/aluCode", 64'(outInfo.aluCode), 64'(0));
`else
    chk("mul/illegal", 64'(outIllegal), 64'(1));
`endif
    cycle("mul_pop", 0, 0, 0, 1, 0);

    for (int i = 0; i < 3; i++) cycle("prefl", 1, rand_insn(), 32'h400 + 32'(i * 4), 0, 0);
    chk("preflush/count", 64'(count), 64'(3));
    cycle("flush", 1, 32'h00500113, 32'h40C, 1, 1);
    chk("flush/count", 64'(count), 64'(0));
    chk("flush/outValid", 64'(outValid), 64'(0));
    chk("flush/inReady", 64'(inReady), 64'(1));
    cycle("postflush", 0, 0, 0, 1, 0);

    for (int i = 0; i < 400; i++) begin
      cycle("rand", ($urandom_range(0, 3) != 0), rand_insn(), $urandom,
            ($urandom_range(0, 2) != 0), ($urandom_range(0, 19) == 0));
    end

    cycle("prerst", 1, rand_insn(), 32'h500, 0, 0);
    cycle("prerst", 1, rand_insn(), 32'h504, 0, 0);
    #2;
    rst = 1'b0;
    #1;
    mq.delete();
    chk("rstmid/outValid", 64'(outValid), 64'(0));
    chk("rstmid/count", 64'(count), 64'(0));
    inValid = 1'b0;
    @(posedge clk); #1;
    rst = 1'b1;
    cycle("postrst", 1, 32'hFFF00093, 32'h600, 0, 0);
    chk("postrst/count", 64'(count), 64'(1));

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/decode_queue.md
# decode_queue

Registered RV32I instruction decoder and in-order buffer between fetch and execute in the pipelined core. Each accepted instruction word is decoded into an `OpInfo` record with a fully sign-extended, format-correct immediate and an illegal-instruction flag, then held in a `DEPTH`-entry FIFO. Decoupling uses valid/ready handshakes, and a flush input supports branch redirects.

## Interface
- `DEPTH`, default 4: FIFO entries; power of two, at least 2.
- `PC_WIDTH`, default `INSN_ADDR_WIDTH`: width of the carried PC.
- `clk` in 1: single clock; all state updates on its rising edge.
- `rst` in 1: reset, asynchronous, active-low.
- `flush` in 1: discard all entries and any same-cycle push.
- `inValid` in 1: fetch offers an instruction.
- `inReady` out 1: the queue can accept.
- `inInsn` in 32: raw instruction word.
- `inPC` in `PC_WIDTH`: PC of `inInsn`.
- `outValid` out 1: the head entry is valid.
- `outReady` in 1: the consumer takes the head.
- `outInfo` out `$bits(OpInfo)`: decoded head record.
- `outPC` out `PC_WIDTH`: PC of the head.
- `outIllegal` out 1: the head opcode or funct combination is unsupported.
- `count` out `$clog2(DEPTH)+1`: number of occupied entries.

## Operation
- **Push:** occurs when `inValid && inReady && !flush`. The decoder runs combinationally on `inInsn`, and the result is written at the tail.
- **Pop:** occurs when `outValid && outReady`. The head pointer advances.
- **Pointers:** read and write pointers are `$clog2(DEPTH)+1` bits. The MSB disambiguates full from empty, and the pointers wrap modulo 2·`DEPTH`.
- **Immediates:** selected by opcode, always sign-extended to 32 bits:
  - I type: LOAD, OP_IMM, JALR.
  - S type: STORE.
  - B type: BRANCH, with bit 0 = 0.
  - U type: LUI, AUIPC, as `imm[31:12]` followed by 12 zero bits.
  - J type: JAL, with bit 0 = 0.
  - OP: constant = 0.
- **Shift immediates:** for SLLI/SRLI/SRAI, `shamt = insn[24:20]` zero-extended. A set `insn[25]` is illegal.
- **Control flags:**
  - `regWrEnable`: set for LOAD, OP, OP_IMM, LUI, AUIPC, JAL, JALR, and cleared when rd = 0.
  - `isBranch`: BRANCH.
  - `isJump`: JAL and JALR.
  - `isLoad`: LOAD.
  - `isStore`: STORE.
  - `isALUInConstant`: OP_IMM, LOAD, STORE, LUI, AUIPC, JALR.
- **Codes:** `aluCode = funct3` for OP and OP_IMM, `ADD_SUB` otherwise. `brCode = funct3`.
- **Illegal:** any unlisted opcode; bits [1:0] ≠ 11; MEM funct3 of 011/11x; BRANCH funct3 of 01x; OP funct7 other than `ADD`/`SUB` (SUB/SRA only for funct3 000/101). An illegal entry has all write, memory and branch flags forced to 0. It is still queued, in order.
- **Occupancy:** simultaneous push and pop leaves `count` unchanged. This is legal at `count == DEPTH` only if `inReady` is high, which it is not (see Timing).
- **Flush:** the next state is empty. Flush beats a same-cycle push and pop, and the offered instruction is dropped.

## Timing
- **Latency:** an accepted instruction appears at `outValid` one cycle after acceptance. There is no combinational bypass.
- **`inReady`:** equals `count < DEPTH`, driven from registered state only. It never depends on `outReady`.
- **`outValid`:** equals `count != 0`. `outInfo`, `outPC` and `outIllegal` are stable while `outValid && !outReady`.
- **Throughput:** sustained one instruction per cycle when `outReady` is held high.
- **Reset values:** pointers 0, `count` = 0, `outValid` = 0, `inReady` = 1, and `outInfo`/`outPC`/`outIllegal` = 0.
- **Reset mid-operation:** asserting `rst` empties the queue immediately and asynchronously. The first push is accepted on the first edge after deassertion.
- **Flush timing:** `flush` is sampled synchronously. On the following cycle `outValid` = 0 and `inReady` = 1.

## Configuration
- **`DECODE_QUEUE_RV32M_EN` defined:** OP with funct7 = 0000001 is legal, `isMulDiv` = 1 and `aluCode = funct3`, covering MUL through REMU.
- **Not defined:** that encoding is illegal and `isMulDiv` is tied to 0.

## Structure
- **Shared package additions:**
  - `ImmType` enum: `IMM_I`, `IMM_S`, `IMM_B`, `IMM_U`, `IMM_J`, `IMM_NONE`.
  - `isMulDiv` and `isIllegal` appended to `OpInfo`.
  - `FUNCT7_MULDIV = 7'b0000001`.
  - `QueueCountPath` is kept local to the block, because it depends on `DEPTH`.
- **Sub-module:** `insn_decoder`, purely combinational, mapping `inInsn` to `OpInfo`. It holds all legality and immediate logic, and the queue instantiates it once on the push path.

## Test plan
- **ADDI:** push `0xFFF00093` (`addi x1,x0,-1`) → next cycle `outValid` = 1, rd = 1, constant = `0xFFFFFFFF`, `regWrEnable` = 1, `isALUInConstant` = 1, `outIllegal` = 0.
- **Immediates and pass-through:**
  - Push `0xFE000EE3` (`beq x0,x0,-4`) → constant = `0xFFFFFFFC`, `isBranch` = 1, `brCode` = 000.
  - Push `0x123452B7` (`lui x5,0x12345`) → constant = `0x12345000`.
  - `outPC` equals `inPC` for each entry.
- **Fill and drain:** hold `outReady` = 0 and push 4 (`DEPTH` = 4) → `count` = 4 and `inReady` = 0. Then raise `outReady` with `inValid` held → drains in order, with `count` reaching 3 and refill resuming the next cycle.
- **Illegal and RV32M:**
  - `0x00000000` → `outIllegal` = 1 and all flags 0.
  - `0x022081B3` (`mul x3,x1,x2`) → `isMulDiv` = 1 with `DECODE_QUEUE_RV32M_EN` defined, `outIllegal` = 1 without it.
- **Flush and reset:**
  - With `count` = 3, assert `flush` with a simultaneous push → next cycle `count` = 0 and the pushed word is absent.
  - Assert `rst` low mid-stream → `outValid` = 0 immediately.
